// File: rtl/exc_ctrl.sv
// Exception/ERET/MTC0 commit controller at writeback: raises CP0 strobes,
// flushes the pipeline for FLUSH_CYC cycles, then redirects fetch.
module exc_ctrl #(
  parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
  parameter int          FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic [4:0]  ws_ex_code,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic [31:0] ws_epc,
  input  logic        ws_mtc0,
  input  logic [4:0]  ws_mtc0_waddr,
  input  logic [31:0] ws_mtc0_wdata,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic        time_int,
  output logic [4:0]  ex_code,
  output logic        bd,
  output logic        eret,
  output logic [31:0] BadVAddr,
  output logic        pc_error,
  output logic [31:0] wdata,
  output logic        mtc0,
  output logic [4:0]  mtc0_waddr,
  output logic [31:0] mtc0_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_e;

  localparam logic [4:0] NO_EX    = 5'h1f;
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYC - 1);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] target_q;

  logic        accept;
  logic        int_pend;
  logic [4:0]  code_d;
  logic        unused_ok;

  // Interrupts need IE=1 and EXL=0; the timer is folded onto IP7.
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause,
                                       input logic        tint);
    logic [7:0] ip;
    ip = cause[15:8] | {tint, 7'b0};
    return status[0] & ~status[1] & (|(ip & status[15:8]));
  endfunction

  assign ws_ready    = (state_q == IDLE);
  assign accept      = ws_valid & ws_ready;
  assign int_pend    = int_pending(cp0_status, cp0_cause, time_int);
  assign code_d      = int_pend ? EXC_INT : ws_ex_code;
  assign redirect_pc = target_q;
  assign unused_ok   = ^{cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:16], cp0_cause[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      target_q       <= '0;
      ex_code        <= NO_EX;
      bd             <= 1'b0;
      eret           <= 1'b0;
      BadVAddr       <= '0;
      pc_error       <= 1'b0;
      wdata          <= '0;
      mtc0           <= 1'b0;
      mtc0_waddr     <= '0;
      mtc0_wdata     <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      // CP0 strobes are single-cycle pulses; fall back to idle values.
      ex_code    <= NO_EX;
      bd         <= 1'b0;
      eret       <= 1'b0;
      BadVAddr   <= '0;
      pc_error   <= 1'b0;
      wdata      <= '0;
      mtc0       <= 1'b0;
      mtc0_waddr <= '0;
      mtc0_wdata <= '0;

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (code_d != NO_EX) begin
              ex_code  <= code_d;
              bd       <= ws_bd;
              wdata    <= ws_pc;
              BadVAddr <= ws_badvaddr;
              pc_error <= (code_d == EXC_ADEL) && (ws_badvaddr == ws_pc);
              target_q <= EX_ENTRY;
              cnt_q    <= CNT_INIT;
              flush    <= 1'b1;
              state_q  <= FLUSH;
            end else if (ws_eret) begin
              eret     <= 1'b1;
              target_q <= ws_epc;
              cnt_q    <= CNT_INIT;
              flush    <= 1'b1;
              state_q  <= FLUSH;
            end else if (ws_mtc0) begin
              mtc0       <= 1'b1;
              mtc0_waddr <= ws_mtc0_waddr;
              mtc0_wdata <= ws_mtc0_wdata;
            end
          end
        end
        FLUSH: begin
          if (cnt_q == 3'd0) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            state_q        <= REDIRECT;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: vector table through a scoreboard queue, plus
// hand-written back-to-back MTC0 and reset-during-flush sequences.
module tb_exc_ctrl;

  localparam logic [31:0] EX_ENTRY  = 32'hbfc00380;
  localparam int          FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_ready, ws_bd, ws_eret, ws_mtc0, time_int;
  logic [4:0]  ws_ex_code, ws_mtc0_waddr;
  logic [31:0] ws_pc, ws_badvaddr, ws_epc, ws_mtc0_wdata, cp0_status, cp0_cause;
  logic [4:0]  ex_code, mtc0_waddr;
  logic        bd, eret, pc_error, mtc0, flush, redirect_valid, redirect_ready;
  logic [31:0] BadVAddr, wdata, mtc0_wdata, redirect_pc;

  exc_ctrl #(.EX_ENTRY(EX_ENTRY), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_ready(ws_ready),
    .ws_ex_code(ws_ex_code), .ws_bd(ws_bd), .ws_pc(ws_pc),
    .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret), .ws_epc(ws_epc),
    .ws_mtc0(ws_mtc0), .ws_mtc0_waddr(ws_mtc0_waddr),
    .ws_mtc0_wdata(ws_mtc0_wdata), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .time_int(time_int), .ex_code(ex_code), .bd(bd),
    .eret(eret), .BadVAddr(BadVAddr), .pc_error(pc_error), .wdata(wdata),
    .mtc0(mtc0), .mtc0_waddr(mtc0_waddr), .mtc0_wdata(mtc0_wdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc, badv;
    logic        er;
    logic [31:0] epc;
    logic        mt;
    logic [4:0]  wa;
    logic [31:0] wd, status, cause;
    logic        ti;
    int          hold;
    logic [4:0]  e_code;
    logic        e_perr, e_eret, e_mtc0, e_flush;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic [4:0] code, input logic b, input logic [31:0] pc, badv,
    input logic er, input logic [31:0] epc, input logic mt,
    input logic [4:0] wa, input logic [31:0] wd, status, cause,
    input logic ti, input int hold, input logic [4:0] e_code,
    input logic e_perr, e_eret, e_mtc0, e_flush, input logic [31:0] e_target);
    vec_t v;
    v.code = code; v.bd = b; v.pc = pc; v.badv = badv; v.er = er;
    v.epc = epc; v.mt = mt; v.wa = wa; v.wd = wd; v.status = status;
    v.cause = cause; v.ti = ti; v.hold = hold; v.e_code = e_code;
    v.e_perr = e_perr; v.e_eret = e_eret; v.e_mtc0 = e_mtc0;
    v.e_flush = e_flush; v.e_target = e_target;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ws_valid = 1'b0; ws_ex_code = 5'h1f; ws_bd = 1'b0; ws_pc = '0;
    ws_badvaddr = '0; ws_eret = 1'b0; ws_epc = '0; ws_mtc0 = 1'b0;
    ws_mtc0_waddr = '0; ws_mtc0_wdata = '0;
  endtask

  task automatic redirect_phase(input logic [31:0] target, input int hold);
    for (int i = 1; i < FLUSH_CYC; i++) begin
      tick();
      chk("flush_hold", flush, 1'b1);
      chk("rv_in_flush", redirect_valid, 1'b0);
      chk("ex_code_in_flush", ex_code, 5'h1f);
    end
    tick();
    chk("flush_end", flush, 1'b0);
    chk("rv_assert", redirect_valid, 1'b1);
    chk("redirect_pc", redirect_pc, target);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rv_held", redirect_valid, 1'b1);
      chk("redirect_pc_stable", redirect_pc, target);
      chk("ready_low_in_redirect", ws_ready, 1'b0);
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("rv_drop", redirect_valid, 1'b0);
    chk("back_to_idle", ws_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    logic exc;
    @(negedge clk);
    chk("ready_before", ws_ready, 1'b1);
    ws_valid = 1'b1; ws_ex_code = v.code; ws_bd = v.bd; ws_pc = v.pc;
    ws_badvaddr = v.badv; ws_eret = v.er; ws_epc = v.epc; ws_mtc0 = v.mt;
    ws_mtc0_waddr = v.wa; ws_mtc0_wdata = v.wd; cp0_status = v.status;
    cp0_cause = v.cause; time_int = v.ti;
    sb.push_back(v);
    tick();
    idle_inputs();
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    exc = (e.e_code != 5'h1f);
    chk("ex_code", ex_code, e.e_code);
    chk("bd", bd, exc ? e.bd : 1'b0);
    chk("pc_error", pc_error, e.e_perr);
    chk("eret", eret, e.e_eret);
    chk("mtc0", mtc0, e.e_mtc0);
    chk("flush_t1", flush, e.e_flush);
    if (exc) begin
      chk("wdata", wdata, e.pc);
      chk("BadVAddr", BadVAddr, e.badv);
    end
    if (e.e_mtc0) begin
      chk("mtc0_waddr", mtc0_waddr, e.wa);
      chk("mtc0_wdata", mtc0_wdata, e.wd);
    end
    if (e.e_flush) begin
      chk("ready_low_t1", ws_ready, 1'b0);
      redirect_phase(e.e_target, e.hold);
    end else begin
      chk("ready_stays", ws_ready, 1'b1);
      chk("no_redirect", redirect_valid, 1'b0);
    end
    cp0_status = '0; cp0_cause = '0; time_int = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              code  bd pc            badv          er epc           mt wa     wd     status        cause         ti hold e_code pe er mt fl target
    vecs[0]  = mk(5'h08, 0, 32'h80001000, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0, 32'h0,        32'h0,        0, 0, 5'h08, 0, 0, 0, 1, EX_ENTRY);
    vecs[1]  = mk(5'h04, 0, 32'h80000002, 32'h80000002, 0, 32'h0,        0, 5'd0,  32'h0, 32'h0,        32'h0,        0, 1, 5'h04, 1, 0, 0, 1, EX_ENTRY);
    vecs[2]  = mk(5'h04, 1, 32'h80000010, 32'h80000020, 0, 32'h0,        0, 5'd0,  32'h0, 32'h0,        32'h0,        0, 0, 5'h04, 0, 0, 0, 1, EX_ENTRY);
    vecs[3]  = mk(5'h1f, 0, 32'h80000100, 32'h0,        1, 32'h80002000, 0, 5'd0,  32'h0, 32'h0,        32'h0,        0, 3, 5'h1f, 0, 1, 0, 1, 32'h80002000);
    vecs[4]  = mk(5'h0c, 0, 32'h80000200, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0, 32'h00008001, 32'h0,        1, 0, 5'h00, 0, 0, 0, 1, EX_ENTRY);
    vecs[5]  = mk(5'h1f, 0, 32'h80000300, 32'h0,        0, 32'h0,        1, 5'd12, 32'h1, 32'h0,        32'h0,        0, 0, 5'h1f, 0, 0, 1, 0, 32'h0);
    vecs[6]  = mk(5'h0c, 0, 32'h80000400, 32'h0,        1, 32'h80005000, 1, 5'd12, 32'h7, 32'h0,        32'h0,        0, 0, 5'h0c, 0, 0, 0, 1, EX_ENTRY);
    vecs[7]  = mk(5'h1f, 0, 32'h80000500, 32'h0,        0, 32'h0,        1, 5'd9,  32'h5, 32'h00008003, 32'h0,        1, 0, 5'h1f, 0, 0, 1, 0, 32'h0);
    vecs[8]  = mk(5'h1f, 1, 32'h80000600, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0, 32'h00000201, 32'h00000200, 0, 2, 5'h00, 0, 0, 0, 1, EX_ENTRY);
    vecs[9]  = mk(5'h1f, 0, 32'h80000700, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0, 32'h0000ff00, 32'h0000ff00, 1, 0, 5'h1f, 0, 0, 0, 0, 32'h0);
    vecs[10] = mk(5'h1f, 0, 32'h80000800, 32'h0,        1, 32'h80006000, 1, 5'd3,  32'h9, 32'h0,        32'h0,        0, 1, 5'h1f, 0, 1, 0, 1, 32'h80006000);

    reset = 1'b1; redirect_ready = 1'b0; idle_inputs();
    cp0_status = '0; cp0_cause = '0; time_int = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ex_code", ex_code, 5'h1f);
    chk("rst_flush", flush, 1'b0);
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_ready", ws_ready, 1'b1);
    chk("rst_eret", eret, 1'b0);
    chk("rst_mtc0", mtc0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Back-to-back MTC0: second instruction accepted on the very next edge.
    @(negedge clk);
    ws_valid = 1'b1; ws_mtc0 = 1'b1; ws_mtc0_waddr = 5'd12; ws_mtc0_wdata = 32'h1;
    tick();
    chk("b2b_mtc0_1", mtc0, 1'b1);
    chk("b2b_waddr_1", mtc0_waddr, 5'd12);
    chk("b2b_wdata_1", mtc0_wdata, 32'h1);
    chk("b2b_flush", flush, 1'b0);
    chk("b2b_ready", ws_ready, 1'b1);
    ws_mtc0_waddr = 5'd13; ws_mtc0_wdata = 32'h2;
    tick();
    chk("b2b_mtc0_2", mtc0, 1'b1);
    chk("b2b_waddr_2", mtc0_waddr, 5'd13);
    chk("b2b_wdata_2", mtc0_wdata, 32'h2);
    idle_inputs();
    tick();
    chk("b2b_mtc0_off", mtc0, 1'b0);

    // Reset during FLUSH aborts the redirect; first edge after release accepts.
    @(negedge clk);
    ws_valid = 1'b1; ws_ex_code = 5'h08; ws_pc = 32'h80001000;
    tick();
    idle_inputs();
    chk("pre_rst_flush", flush, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_flush", flush, 1'b0);
    chk("async_rst_rv", redirect_valid, 1'b0);
    chk("async_rst_ex_code", ex_code, 5'h1f);
    chk("async_rst_ready", ws_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    ws_valid = 1'b1; ws_ex_code = 5'h0c; ws_pc = 32'h80003000;
    tick();
    idle_inputs();
    chk("post_rst_ex_code", ex_code, 5'h0c);
    chk("post_rst_wdata", wdata, 32'h80003000);
    chk("post_rst_flush", flush, 1'b1);
    redirect_phase(EX_ENTRY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameters, one per line: name, default, meaning.
- EX_ENTRY, 32'hbfc00380, exception vector.
- FLUSH_CYC, 2, flush pulse length in cycles (1..7).
REQ-003 Ports, one per line: name  direction  width  meaning.
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- ws_valid  in  1  WB instruction valid.
- ws_ready  out  1  WB instruction accepted this cycle.
- ws_ex_code  in  5  WB exception code; 5'h1f = NO_EX.
- ws_bd  in  1  instruction in delay slot.
- ws_pc  in  32  instruction PC.
- ws_badvaddr  in  32  faulting address.
- ws_eret  in  1  ERET.
- ws_epc  in  32  current CP0 EPC (ERET target).
- ws_mtc0  in  1  MTC0.
- ws_mtc0_waddr  in  5  MTC0 register number.
- ws_mtc0_wdata  in  32  MTC0 data.
- cp0_status  in  32  CP0 Status read value.
- cp0_cause  in  32  CP0 Cause read value.
- time_int  in  1  timer interrupt.
- ex_code  out  5  to CP0.
- bd  out  1  to CP0.
- eret  out  1  to CP0.
- BadVAddr  out  32  to CP0.
- pc_error  out  1  to CP0.
- wdata  out  32  EPC source to CP0.
- mtc0  out  1  to CP0.
- mtc0_waddr  out  5  to CP0.
- mtc0_wdata  out  32  to CP0.
- flush  out  1  pipeline flush.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  fetch accepts redirect.

Function
REQ-004 SHALL implement FSM states IDLE, FLUSH, REDIRECT.
REQ-005 SHALL assert ws_ready only in IDLE; accept = ws_valid & ws_ready.
REQ-006 SHALL compute int_pend = Status[0] & ~Status[1] & |((Cause[15:8] | {time_int,7'b0}) & Status[15:8]).
REQ-007 On accept, SHALL select the effective code in priority order: int_pend -> 5'h00; else ws_ex_code.
REQ-008 On accept with an effective code other than NO_EX, SHALL register outputs for exactly one cycle (T+1):
- ex_code = effective code.
- bd = ws_bd.
- wdata = ws_pc.
- BadVAddr = ws_badvaddr.
- pc_error = (code==5'h04 & ws_badvaddr==ws_pc).
REQ-009 On accept with NO_EX and ws_eret, SHALL pulse eret for one cycle (T+1) and hold ex_code = NO_EX.
REQ-010 On accept with NO_EX and ws_mtc0 and no eret, SHALL pulse mtc0, mtc0_waddr and mtc0_wdata for one cycle (T+1); no flush.
REQ-011 An exception SHALL suppress the eret and mtc0 pulses of the same instruction.
REQ-012 Exception or ERET accept SHALL enter FLUSH at T+1 and assert flush for FLUSH_CYC cycles via a 3-bit down-counter, then enter REDIRECT.
REQ-013 REDIRECT SHALL assert redirect_valid with redirect_pc = EX_ENTRY (exception) or the ws_epc captured at accept (ERET).
- Holds until redirect_valid & redirect_ready, then IDLE next cycle.
REQ-014 SHALL hold redirect_pc stable while redirect_valid=1.
REQ-015 SHALL ignore ws_valid outside IDLE; inputs are not sampled in FLUSH or REDIRECT.
REQ-016 Idle output values SHALL be:
- ex_code = 5'h1f.
- All other CP0 strobes = 0.
- flush = 0.
- redirect_valid = 0.
REQ-017 A non-exception, non-eret instruction SHALL stay in IDLE, with ws_ready=1 on back-to-back cycles.

Reset
REQ-018 Reset SHALL force IDLE and the REQ-016 idle values immediately (asynchronous), clear the counter and captured target, and abort any in-progress FLUSH or REDIRECT without completing.
REQ-019 First accept SHALL occur on the first edge after reset deassertion.

Verification
REQ-020 SHALL cover:
- ws_ex_code=5'h08, ws_pc=32'h80001000, ws_bd=0 -> T+1 ex_code=08, wdata=80001000, bd=0; flush T+1..T+2; redirect_pc=bfc00380.
- ADEL with ws_badvaddr=ws_pc=32'h80000002 -> ex_code=04, pc_error=1, BadVAddr=80000002.
- ERET, ws_epc=32'h80002000, redirect_ready low 3 cycles -> eret pulse 1 cycle; redirect_valid held 3+ cycles with target 80002000; IDLE after handshake.
- Status=32'h0000_8001, time_int=1, ws_ex_code=5'h0c -> ex_code=00 (interrupt wins).
- MTC0 waddr=12, wdata=32'h1 -> mtc0 pulse 1 cycle; flush=0; next instruction accepted next cycle.
- Reset asserted in FLUSH -> flush=0, redirect_valid=0 immediately; next ws_valid accepted after release.
